// File: rtl/usart_rx_fifo_pkg.sv
// Shared definitions for the receive buffer: default widths, ingress FSM
// state encoding and the layout of one stored entry.
package usart_rx_fifo_pkg;

  // Character width; must track the width of usart_rx data_out.
  localparam int DATA_WIDTH_DEF = 8;

  // Buffer depth is 2**DEPTH_LOG2 entries.
  localparam int DEPTH_LOG2_DEF = 4;

  // Ingress handshake states. S_ACK drives acknowledge back to usart_rx.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } rx_state_e;

  // Entry layout is {error, data}: the framing-error tag sits directly above
  // the character bits, so an entry is DATA_WIDTH+1 bits wide.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/usart_rx_fifo_ram.sv
// Entry storage for the receive buffer: one synchronous write port and an
// asynchronous read port so the head entry is visible without a read cycle.
module usart_rx_fifo_ram #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 9
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Contents are never reset: an entry is only observed after it was written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming entry at the write pointer.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Head entry is read combinationally (first-word-fall-through).
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/usart_rx_fifo.sv
// Receive buffer behind usart_rx. Drains each character through the
// available/acknowledge handshake into a FIFO tagged with its framing error,
// presents the head entry to the CPU side and flags overrun when a character
// had to be dropped. usart_rx is never stalled.
module usart_rx_fifo
  import usart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  comm_clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_available,
  input  logic                  rx_error,
  output logic                  rx_acknowledge,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_error,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  localparam int EW = entry_width(DATA_WIDTH);
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

  rx_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic                  capture;
  logic                  do_push;
  logic                  do_pop;
  logic                  drop;
  logic                  empty_w;
  logic                  full_w;
  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         rd_entry;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_COUNT);

  // A full buffer still accepts a character when the CPU pops in the same
  // cycle, since the slot being freed is the one written.
  assign do_pop  = read_strobe && !empty_w;
  assign do_push = capture && (!full_w || read_strobe);
  assign drop    = capture && full_w && !read_strobe;

  assign wr_entry = {rx_error, rx_data};

  // Ingress FSM next state: capture exactly once per available assertion,
  // then hold acknowledge until usart_rx withdraws available.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_available) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!rx_available) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, occupancy and sticky overrun next-state; overrun set wins over clear.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // State, pointers, count and overrun registers; reset drops acknowledge at once.
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  usart_rx_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (EW)
  ) u_ram (
    .clk_i     (comm_clock),
    .wr_en_i   (do_push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  assign rx_acknowledge = (state_q == S_ACK);
  assign data_out       = rd_entry[DATA_WIDTH-1:0];
  assign data_error     = rd_entry[DATA_WIDTH];
  assign empty          = empty_w;
  assign full           = full_w;
  assign count          = count_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Directed bench for usart_rx_fifo: a table of characters drives fill/drain
// passes, hand-written sequences cover handshake timing, overrun, concurrent
// push/pop on full, error tagging and reset during acknowledge.
module tb_usart_rx_fifo;

  logic       comm_clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_error;
  logic       rx_acknowledge;
  logic       read_strobe;
  logic [7:0] data_out;
  logic       data_error;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clear_overrun;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] din;
    logic       ein;
    logic [4:0] exp_count;
  } vec_t;

  vec_t vecs [16];

  usart_rx_fifo dut (
    .comm_clock     (comm_clock),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_available   (rx_available),
    .rx_error       (rx_error),
    .rx_acknowledge (rx_acknowledge),
    .read_strobe    (read_strobe),
    .data_out       (data_out),
    .data_error     (data_error),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overrun        (overrun),
    .clear_overrun  (clear_overrun)
  );

  always #5 comm_clock = ~comm_clock;

  task automatic tick();
    @(posedge comm_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Full handshake as usart_rx would do it, with bounded waits.
  task automatic push(input logic [7:0] d, input logic e);
    int n;
    rx_data      = d;
    rx_error     = e;
    rx_available = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rx_acknowledge && n < 8);
    if (!rx_acknowledge) begin
      tests++;
      fails++;
      $display("FAIL push_ack_timeout: got ack=0 expected ack=1 within 8 cycles");
    end
    rx_available = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (rx_acknowledge && n < 8);
    if (rx_acknowledge) begin
      tests++;
      fails++;
      $display("FAIL push_ack_release: got ack=1 expected ack=0 within 8 cycles");
    end
    tick();
  endtask

  task automatic pop();
    read_strobe = 1'b1;
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic fill_table();
    for (int i = 0; i < 16; i++) begin
      push(vecs[i].din, vecs[i].ein);
      check($sformatf("fill_count[%0d]", i), 32'(count), 32'(vecs[i].exp_count));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecs[i].din       = 8'(i);
      vecs[i].ein       = 1'b0;
      vecs[i].exp_count = 5'(i + 1);
    end

    reset         = 1'b1;
    rx_data       = 8'h00;
    rx_available  = 1'b0;
    rx_error      = 1'b0;
    read_strobe   = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_ack", 32'(rx_acknowledge), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // 1: single push, acknowledge one cycle after capture
    rx_data      = 8'hAA;
    rx_error     = 1'b0;
    rx_available = 1'b1;
    check("t1_ack_before_capture", 32'(rx_acknowledge), 32'd0);
    tick();
    check("t1_ack_after_capture", 32'(rx_acknowledge), 32'd1);
    check("t1_count", 32'(count), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_data", 32'(data_out), 32'hAA);
    check("t1_error", 32'(data_error), 32'd0);
    rx_available = 1'b0;
    tick();
    check("t1_ack_drop", 32'(rx_acknowledge), 32'd0);
    pop();
    check("t1_count_after_pop", 32'(count), 32'd0);

    // 2: available held 10 cycles gives one push only
    rx_data      = 8'h3C;
    rx_available = 1'b1;
    repeat (10) tick();
    check("t2_count_single", 32'(count), 32'd1);
    check("t2_ack_held", 32'(rx_acknowledge), 32'd1);
    rx_available = 1'b0;
    tick();
    check("t2_ack_fall", 32'(rx_acknowledge), 32'd0);
    check("t2_count_still", 32'(count), 32'd1);
    check("t2_data", 32'(data_out), 32'h3C);
    pop();
    check("t2_empty", 32'(empty), 32'd1);

    // 3: fill 16, overflow drops 8'h55, drain in order
    fill_table();
    check("t3_full", 32'(full), 32'd1);
    push(8'h55, 1'b0);
    check("t3_full_after_drop", 32'(full), 32'd1);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_pop_data[%0d]", i), 32'(data_out), 32'(vecs[i].din));
      check($sformatf("t3_pop_err[%0d]", i), 32'(data_error), 32'(vecs[i].ein));
      pop();
    end
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_count_zero", 32'(count), 32'd0);

    // 4: push into full with simultaneous pop
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("t4_overrun_cleared", 32'(overrun), 32'd0);
    fill_table();
    rx_data      = 8'h77;
    rx_error     = 1'b0;
    rx_available = 1'b1;
    read_strobe  = 1'b1;
    tick();
    read_strobe  = 1'b0;
    check("t4_count", 32'(count), 32'd16);
    check("t4_overrun", 32'(overrun), 32'd0);
    check("t4_head", 32'(data_out), 32'h01);
    rx_available = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t4_pop_data[%0d]", i), 32'(data_out), 32'(vecs[i + 1].din));
      pop();
    end
    check("t4_last", 32'(data_out), 32'h77);
    pop();
    check("t4_empty", 32'(empty), 32'd1);

    // 5: error tag stays with its entry; pop while empty ignored
    push(8'hFF, 1'b1);
    push(8'h12, 1'b0);
    check("t5_data0", 32'(data_out), 32'hFF);
    check("t5_err0", 32'(data_error), 32'd1);
    pop();
    check("t5_data1", 32'(data_out), 32'h12);
    check("t5_err1", 32'(data_error), 32'd0);
    pop();
    check("t5_count0", 32'(count), 32'd0);
    pop();
    check("t5_empty_pop_count", 32'(count), 32'd0);
    check("t5_empty_pop_empty", 32'(empty), 32'd1);
    push(8'h5A, 1'b0);
    check("t5_ptr_intact", 32'(data_out), 32'h5A);
    pop();

    // 6: asynchronous reset during acknowledge
    push(8'h21, 1'b0);
    push(8'h22, 1'b0);
    push(8'h23, 1'b0);
    rx_data      = 8'h99;
    rx_available = 1'b1;
    tick();
    check("t6_ack_before_reset", 32'(rx_acknowledge), 32'd1);
    check("t6_count_before_reset", 32'(count), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("t6_ack_async", 32'(rx_acknowledge), 32'd0);
    check("t6_count_async", 32'(count), 32'd0);
    check("t6_empty_async", 32'(empty), 32'd1);
    rx_available = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("t6_count_after_release", 32'(count), 32'd0);

    // 6b: overrun set wins over clear in the same cycle
    fill_table();
    check("t6b_overrun_before", 32'(overrun), 32'd0);
    rx_data       = 8'hEE;
    rx_available  = 1'b1;
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("t6b_overrun_set_wins", 32'(overrun), 32'd1);
    check("t6b_count", 32'(count), 32'd16);
    rx_available = 1'b0;
    repeat (2) tick();
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("t6b_overrun_cleared", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
